mips_mem_arbiter: RTL and testbench

Shares one unified memory port between the MIPS32 core's instruction-fetch and data-access interfaces. Port directions are named from the CPU's point of view (X_In flows into the CPU).
Sits between the core and the memory model or memory controller. It serialises requests, holds the memory command stable until the memory completes it, and returns a one-cycle Ready to the requester that was granted.
Data access has priority, with a starvation guard that protects instruction fetch. A timeout watchdog flags a memory that never responds.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mips_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the MIPS32 unified-memory arbiter.
package mips_mem_pkg;

    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned DATA_W      = 32;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE,
        DBUSY,
        IBUSY,
        RESP
    } state_t;

    // Which requester owns the current transaction
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DATA,
        GNT_INST
    } gnt_t;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access.
// Data wins ties, but a streak counter forces a pending fetch through after
// MAX_DATA_STREAK consecutive data grants. A watchdog ends transactions the
// memory never acknowledges and raises a sticky Mem_Timeout flag.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 256,
    parameter int unsigned WRITE_ACK       = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   InstMem_Read,
    input  logic [WORD_ADDR_W-1:0] InstMem_Address,
    output logic [DATA_W-1:0]      InstMem_In,
    output logic                   InstMem_Ready,
    input  logic                   DataMem_Read,
    input  logic [3:0]             DataMem_Write,
    input  logic [WORD_ADDR_W-1:0] DataMem_Address,
    input  logic [DATA_W-1:0]      DataMem_Out,
    output logic [DATA_W-1:0]      DataMem_In,
    output logic                   DataMem_Ready,
    output logic                   Mem_Read,
    output logic [3:0]             Mem_Write,
    output logic [WORD_ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0]      Mem_WriteData,
    input  logic [DATA_W-1:0]      Mem_ReadData,
    input  logic                   Mem_Ready,
    output logic                   Mem_Timeout
);

    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam int unsigned TIMER_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    // Timer holds the number of BUSY cycles already completed, so expiry is
    // detected in the TIMEOUT_CYCLES-th BUSY cycle.
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    gnt_t                   gnt_q, gnt_d;
    logic [STREAK_W-1:0]    streak_q, streak_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   mem_read_q, mem_read_d;
    logic [3:0]             mem_write_q, mem_write_d;
    logic [WORD_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]      inst_in_q, inst_in_d;
    logic [DATA_W-1:0]      data_in_q, data_in_d;
    logic                   timeout_q, timeout_d;

    logic data_req;
    gnt_t grant;
    logic mem_done;
    logic timeout_hit;
    logic complete;

    // Request classification and the IDLE-state grant decision
    always_comb begin
        data_req = DataMem_Read | (|DataMem_Write);
        grant    = GNT_NONE;
        if (data_req && !(InstMem_Read && (streak_q >= STREAK_MAX))) begin
            grant = GNT_DATA;
        end else if (InstMem_Read) begin
            grant = GNT_INST;
        end
    end

    // Completion detection while a command is outstanding
    always_comb begin
        if (mem_read_q) begin
            mem_done = Mem_Ready;
        end else if (WRITE_ACK != 0) begin
            mem_done = Mem_Ready;
        end else begin
            // Unacknowledged writes finish in their first BUSY cycle
            mem_done = (timer_q == '0);
        end
        timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST);
        complete    = mem_done | timeout_hit;
    end

    // Next-state, command and capture logic
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        streak_d    = streak_q;
        timer_d     = timer_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        inst_in_d   = inst_in_q;
        data_in_d   = data_in_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = grant;
                if (grant == GNT_DATA) begin
                    state_d    = DBUSY;
                    timer_d    = '0;
                    mem_read_d = DataMem_Read;
                    mem_addr_d = DataMem_Address;
                    // A simultaneous read and write is treated as a read
                    mem_write_d = DataMem_Read ? 4'b0000 : DataMem_Write;
                    mem_wdata_d = DataMem_Read ? '0 : DataMem_Out;
                    if (!InstMem_Read) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (grant == GNT_INST) begin
                    state_d     = IBUSY;
                    timer_d     = '0;
                    mem_read_d  = 1'b1;
                    mem_write_d = 4'b0000;
                    mem_addr_d  = InstMem_Address;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end
            end
            DBUSY, IBUSY: begin
                if (complete) begin
                    state_d     = RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 4'b0000;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (mem_read_q) begin
                        if (state_q == IBUSY) begin
                            inst_in_d = Mem_ReadData;
                        end else begin
                            data_in_d = Mem_ReadData;
                        end
                    end
                    if (timeout_hit && !mem_done) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                // Turnaround: no grant here, so a still-held request is not re-issued
                state_d = IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_NONE;
            streak_q    <= '0;
            timer_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            inst_in_q   <= '0;
            data_in_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            streak_q    <= streak_d;
            timer_q     <= timer_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            inst_in_q   <= inst_in_d;
            data_in_q   <= data_in_d;
            timeout_q   <= timeout_d;
        end
    end

    // Outputs: Ready pulses only in RESP, to the side that was granted
    always_comb begin
        InstMem_Ready = (state_q == RESP) && (gnt_q == GNT_INST);
        DataMem_Ready = (state_q == RESP) && (gnt_q == GNT_DATA);
        InstMem_In    = inst_in_q;
        DataMem_In    = data_in_q;
        Mem_Read      = mem_read_q;
        Mem_Write     = mem_write_q;
        Mem_Address   = mem_addr_q;
        Mem_WriteData = mem_wdata_q;
        Mem_Timeout   = timeout_q;
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter with a 1-cycle memory model.
module tb_mips_mem_arbiter;
    import mips_mem_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   InstMem_Read = 1'b0;
    logic [WORD_ADDR_W-1:0] InstMem_Address = '0;
    logic [DATA_W-1:0]      InstMem_In;
    logic                   InstMem_Ready;
    logic                   DataMem_Read = 1'b0;
    logic [3:0]             DataMem_Write = 4'b0000;
    logic [WORD_ADDR_W-1:0] DataMem_Address = '0;
    logic [DATA_W-1:0]      DataMem_Out = '0;
    logic [DATA_W-1:0]      DataMem_In;
    logic                   DataMem_Ready;
    logic                   Mem_Read;
    logic [3:0]             Mem_Write;
    logic [WORD_ADDR_W-1:0] Mem_Address;
    logic [DATA_W-1:0]      Mem_WriteData;
    logic [DATA_W-1:0]      Mem_ReadData;
    logic                   Mem_Ready = 1'b0;
    logic                   Mem_Timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] iq[$];
    logic [DATA_W-1:0] dq[$];
    logic [DATA_W-1:0] exp_dlast = '0;
    logic mem_en = 1'b1;

    bit log_en = 1'b0;
    bit glog[$];
    int gaps[$];
    int gap_cnt = 0;
    bit prev_cmd = 1'b0;

    always #5 clock = ~clock;

    mips_mem_arbiter #(
        .MAX_DATA_STREAK(4),
        .TIMEOUT_CYCLES (8),
        .WRITE_ACK      (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .InstMem_Read   (InstMem_Read),
        .InstMem_Address(InstMem_Address),
        .InstMem_In     (InstMem_In),
        .InstMem_Ready  (InstMem_Ready),
        .DataMem_Read   (DataMem_Read),
        .DataMem_Write  (DataMem_Write),
        .DataMem_Address(DataMem_Address),
        .DataMem_Out    (DataMem_Out),
        .DataMem_In     (DataMem_In),
        .DataMem_Ready  (DataMem_Ready),
        .Mem_Read       (Mem_Read),
        .Mem_Write      (Mem_Write),
        .Mem_Address    (Mem_Address),
        .Mem_WriteData  (Mem_WriteData),
        .Mem_ReadData   (Mem_ReadData),
        .Mem_Ready      (Mem_Ready),
        .Mem_Timeout    (Mem_Timeout)
    );

    function automatic logic [DATA_W-1:0] mem_word(input logic [WORD_ADDR_W-1:0] a);
        if (a == 30'h100) return 32'h2402000A;
        return {2'b10, a} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: read data combinational, Mem_Ready one cycle after a read
    assign Mem_ReadData = mem_word(Mem_Address);
    always @(posedge clock) begin
        if (reset || !mem_en) Mem_Ready <= 1'b0;
        else                  Mem_Ready <= Mem_Read && !Mem_Ready;
    end

    // Scoreboard: pop and compare on every Ready pulse
    always @(negedge clock) begin
        if (!reset) begin
            if (InstMem_Ready && DataMem_Ready) begin
                n_checks++; n_fail++;
                $display("FAIL both_ready: got both Ready=1, required at most one");
            end
            if (InstMem_Ready) begin
                n_checks++;
                if (iq.size() == 0) begin
                    n_fail++;
                    $display("FAIL inst_ready_spurious: got InstMem_Ready=1, required 0");
                end else begin
                    logic [DATA_W-1:0] e;
                    e = iq.pop_front();
                    if (InstMem_In !== e) begin
                        n_fail++;
                        $display("FAIL inst_data: got %h, required %h", InstMem_In, e);
                    end
                end
            end
            if (DataMem_Ready) begin
                n_checks++;
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL data_ready_spurious: got DataMem_Ready=1, required 0");
                end else begin
                    logic [DATA_W-1:0] e;
                    e = dq.pop_front();
                    if (DataMem_In !== e) begin
                        n_fail++;
                        $display("FAIL data_data: got %h, required %h", DataMem_In, e);
                    end
                end
            end
        end
    end

    // Grant-order and inter-command gap logger (data addresses have bit 29 set)
    always @(negedge clock) begin
        bit cmd;
        cmd = Mem_Read || (Mem_Write != 4'b0000);
        if (log_en) begin
            if (cmd && !prev_cmd) begin
                if (glog.size() > 0) gaps.push_back(gap_cnt);
                glog.push_back(Mem_Address[29]);
            end
            if (cmd) gap_cnt = 0;
            else     gap_cnt++;
        end
        prev_cmd = cmd;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input bit data_side, input int limit, output int cycles);
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (data_side ? DataMem_Ready : InstMem_Ready) begin
                cycles = i;
                return;
            end
        end
        cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({InstMem_In, InstMem_Ready, DataMem_In, DataMem_Ready, Mem_Read, Mem_Write,
             Mem_Address, Mem_WriteData} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero (Mem_Read=%b Mem_Address=%h), required 0",
                     Mem_Read, Mem_Address);
        end
        n_checks++;
        if (Mem_Timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_timeout: got %b, required 0", Mem_Timeout);
        end
        reset = 1'b0;
        exp_dlast = '0;
        tick();
    endtask

    task automatic test_fetch();
        InstMem_Address = 30'h100;
        InstMem_Read = 1'b1;
        iq.push_back(32'h2402000A);
        tick();
        n_checks++;
        if (Mem_Read !== 1'b1 || Mem_Address !== 30'h100 || Mem_Write !== 4'b0) begin
            n_fail++;
            $display("FAIL fetch_cmd: got rd=%b addr=%h we=%b, required rd=1 addr=100 we=0",
                     Mem_Read, Mem_Address, Mem_Write);
        end
        tick();
        n_checks++;
        if (InstMem_Ready !== 1'b0 || Mem_Read !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_hold: got ready=%b rd=%b, required ready=0 rd=1",
                     InstMem_Ready, Mem_Read);
        end
        tick();
        n_checks++;
        if (InstMem_Ready !== 1'b1 || InstMem_In !== 32'h2402000A || Mem_Read !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp: got ready=%b data=%h rd=%b, required 1 2402000a 0",
                     InstMem_Ready, InstMem_In, Mem_Read);
        end
        InstMem_Read = 1'b0;
        tick();
        n_checks++;
        if (InstMem_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_pulse_width: got ready=%b, required 0", InstMem_Ready);
        end
    endtask

    task automatic test_load();
        int c;
        DataMem_Address = 30'h2000_0010;
        DataMem_Read = 1'b1;
        exp_dlast = mem_word(30'h2000_0010);
        dq.push_back(exp_dlast);
        wait_ready(1'b1, 20, c);
        DataMem_Read = 1'b0;
        n_checks++;
        if (c != 3 || DataMem_In !== exp_dlast) begin
            n_fail++;
            $display("FAIL load_latency: got cycles=%0d data=%h, required 3 %h",
                     c, DataMem_In, exp_dlast);
        end
        tick();
    endtask

    task automatic test_store();
        DataMem_Write = 4'b0011;
        DataMem_Address = 30'h801;
        DataMem_Out = 32'h0000ACED;
        dq.push_back(exp_dlast);
        tick();
        n_checks++;
        if (Mem_Write !== 4'b0011 || Mem_Address !== 30'h801 || Mem_WriteData !== 32'h0000ACED
            || Mem_Read !== 1'b0) begin
            n_fail++;
            $display("FAIL store_cmd: got we=%b addr=%h wd=%h rd=%b, required 0011 801 0000aced 0",
                     Mem_Write, Mem_Address, Mem_WriteData, Mem_Read);
        end
        tick();
        n_checks++;
        if (DataMem_Ready !== 1'b1 || Mem_Write !== 4'b0000 || DataMem_In !== exp_dlast) begin
            n_fail++;
            $display("FAIL store_resp: got ready=%b we=%b data=%h, required 1 0000 %h",
                     DataMem_Ready, Mem_Write, DataMem_In, exp_dlast);
        end
        DataMem_Write = 4'b0000;
        tick();
        n_checks++;
        if (DataMem_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL store_pulse_width: got ready=%b, required 0", DataMem_Ready);
        end
    endtask

    task automatic test_read_write_conflict();
        int pulses = 0;
        DataMem_Read = 1'b1;
        DataMem_Write = 4'hF;
        DataMem_Address = 30'h2000_0022;
        DataMem_Out = 32'hDEADBEEF;
        exp_dlast = mem_word(30'h2000_0022);
        dq.push_back(exp_dlast);
        tick();
        n_checks++;
        if (Mem_Read !== 1'b1 || Mem_Write !== 4'b0000) begin
            n_fail++;
            $display("FAIL rw_cmd: got rd=%b we=%b, required rd=1 we=0000", Mem_Read, Mem_Write);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (DataMem_Ready) begin
                pulses++;
                DataMem_Read = 1'b0;
                DataMem_Write = 4'b0000;
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL rw_ready_count: got %0d pulses, required 1", pulses);
        end
    endtask

    task automatic test_streak();
        logic [WORD_ADDR_W-1:0] ia = 30'h200;
        logic [WORD_ADDR_W-1:0] da = 30'h2000_0100;
        int n;
        glog.delete();
        gaps.delete();
        log_en = 1'b1;
        InstMem_Address = ia;
        InstMem_Read = 1'b1;
        iq.push_back(mem_word(ia));
        DataMem_Address = da;
        DataMem_Read = 1'b1;
        exp_dlast = mem_word(da);
        dq.push_back(exp_dlast);
        for (int i = 0; i < 300 && (InstMem_Read || DataMem_Read); i++) begin
            tick();
            if (InstMem_Ready) begin
                if (glog.size() < 10) begin
                    ia = ia + 1'b1;
                    InstMem_Address = ia;
                    iq.push_back(mem_word(ia));
                end else begin
                    InstMem_Read = 1'b0;
                end
            end
            if (DataMem_Ready) begin
                if (glog.size() < 10) begin
                    da = da + 1'b1;
                    DataMem_Address = da;
                    exp_dlast = mem_word(da);
                    dq.push_back(exp_dlast);
                end else begin
                    DataMem_Read = 1'b0;
                end
            end
        end
        tick();
        tick();
        log_en = 1'b0;
        n_checks++;
        if (InstMem_Read || DataMem_Read || glog.size() < 10) begin
            n_fail++;
            $display("FAIL streak_progress: got %0d grants, required >= 10 and drained",
                     glog.size());
            InstMem_Read = 1'b0;
            DataMem_Read = 1'b0;
        end
        n = (glog.size() < 10) ? glog.size() : 10;
        for (int i = 0; i < n; i++) begin
            bit exp_d;
            exp_d = ((i % 5) != 4);
            n_checks++;
            if (glog[i] !== exp_d) begin
                n_fail++;
                $display("FAIL streak_order[%0d]: got %s, required %s", i,
                         glog[i] ? "D" : "I", exp_d ? "D" : "I");
            end
        end
        for (int i = 0; i < gaps.size(); i++) begin
            n_checks++;
            if (gaps[i] != 2) begin
                n_fail++;
                $display("FAIL streak_gap[%0d]: got %0d idle cycles, required 2", i, gaps[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int c;
        n_checks++;
        if (Mem_Timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre: got %b, required 0", Mem_Timeout);
        end
        mem_en = 1'b0;
        InstMem_Address = 30'h40;
        InstMem_Read = 1'b1;
        iq.push_back(mem_word(30'h40));
        wait_ready(1'b0, 30, c);
        InstMem_Read = 1'b0;
        n_checks++;
        if (c != 9 || Mem_Timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_expiry: got cycles=%0d flag=%b, required 9 1", c, Mem_Timeout);
        end
        tick();
        mem_en = 1'b1;
        DataMem_Address = 30'h2000_0033;
        DataMem_Read = 1'b1;
        exp_dlast = mem_word(30'h2000_0033);
        dq.push_back(exp_dlast);
        wait_ready(1'b1, 20, c);
        DataMem_Read = 1'b0;
        n_checks++;
        if (c != 3 || Mem_Timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got cycles=%0d flag=%b, required 3 1", c, Mem_Timeout);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        int dpulses = 0;
        mem_en = 1'b0;
        DataMem_Address = 30'h2000_0044;
        DataMem_Read = 1'b1;
        tick();
        tick();
        n_checks++;
        if (Mem_Read !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy: got rd=%b, required 1", Mem_Read);
        end
        reset = 1'b1;
        DataMem_Read = 1'b0;
        tick();
        n_checks++;
        if ({InstMem_In, InstMem_Ready, DataMem_In, DataMem_Ready, Mem_Read, Mem_Write,
             Mem_Address, Mem_WriteData, Mem_Timeout} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rd=%b addr=%h to=%b, required all 0",
                     Mem_Read, Mem_Address, Mem_Timeout);
        end
        reset = 1'b0;
        mem_en = 1'b1;
        exp_dlast = '0;
        tick();
        InstMem_Address = 30'h300;
        InstMem_Read = 1'b1;
        iq.push_back(mem_word(30'h300));
        for (c = 1; c <= 20; c++) begin
            tick();
            if (DataMem_Ready) dpulses++;
            if (InstMem_Ready) break;
        end
        InstMem_Read = 1'b0;
        n_checks++;
        if (c != 3 || dpulses != 0) begin
            n_fail++;
            $display("FAIL midreset_fetch: got cycles=%0d data_pulses=%0d, required 3 0",
                     c, dpulses);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_read_write_conflict();
        test_streak();
        test_timeout();
        test_reset_mid();
        repeat (3) tick();
        n_checks++;
        if (iq.size() != 0 || dq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d inst %0d data left, required 0 0",
                     iq.size(), dq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
